// File: rtl/mxv_frame_tx_pkg.sv
// Shared definitions for the MxV response framer.
//   FRAME_SOF / FRAME_EOF : frame delimiter bytes
//   CMD_*                 : command codes echoed in the CMD byte
//   frame_tx_state_t      : framer FSM state encoding
//   frame_len()           : LEN byte for a given result count
package mxv_frame_tx_pkg;

  localparam logic [7:0] FRAME_SOF = 8'hFE;
  localparam logic [7:0] FRAME_EOF = 8'hEF;

  localparam logic [7:0] CMD_MAT_SIZE = 8'h01;
  localparam logic [7:0] CMD_MAT_DATA = 8'h02;
  localparam logic [7:0] CMD_VEC_SIZE = 8'h03;
  localparam logic [7:0] CMD_RESULT   = 8'h04;
  localparam logic [7:0] CMD_VEC      = 8'h05;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_LEN,
    ST_CMD,
    ST_FETCH,
    ST_WAIT,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_EOF,
    ST_DONE
  } frame_tx_state_t;

  // LEN counts CMD, two bytes per result and the optional checksum byte.
  function automatic logic [7:0] frame_len(input logic [7:0] cnt, input logic chk);
    return 8'd1 + {cnt[6:0], 1'b0} + {7'd0, chk};
  endfunction

endpackage

// File: rtl/mxv_frame_tx_xor_acc.sv
// frame_xor_acc: 8-bit running XOR of framed bytes (checksum builds only).
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear accumulator (start of a new frame)
//   en       : fold din into the accumulator
//   din      : byte to fold
//   acc      : current accumulator value
module frame_xor_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= 8'h00;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/mxv_frame_tx.sv
// mxv_frame_tx: response framer for the MxV UART link.
// On start, fetches up to MAX_RES results and emits
//   FE, LEN, CMD, {res[15:8], res[7:0]} x Cnt, [CHK], EF
// Build option: define MXV_FRAME_TX_CHECKSUM_EN to insert an XOR checksum
// byte (LEN, CMD and payload) before EF.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, cmd, res_count  frame request (sampled in IDLE only)
//   res_rd_addr/en/data    result buffer read port, 1-cycle read latency
//   tx_data/valid/ready    byte stream to the UART transmitter
//   busy, done             frame in progress / 1-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// SOF   | presenting 0xFE
// LEN   | presenting LEN
// CMD   | presenting echoed command
// FETCH | buffer read issued for result idx
// WAIT  | read data arrives, latched into HI/LO
// HI    | presenting result[15:8]
// LO    | presenting result[7:0]
// CHK   | presenting checksum (checksum builds)
// EOF   | presenting 0xEF
// DONE  | raising done, dropping busy
module mxv_frame_tx
  import mxv_frame_tx_pkg::*;
#(
  parameter  int RES_W   = 16,
  parameter  int MAX_RES = 16,
  localparam int AW      = $clog2(MAX_RES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       cmd,
  input  logic [AW:0]      res_count,
  output logic [AW-1:0]    res_rd_addr,
  output logic             res_rd_en,
  input  logic [RES_W-1:0] res_rd_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [AW:0] MAX_CNT = MAX_RES[AW:0];

  frame_tx_state_t state;
  logic [7:0]  cmd_q;
  logic [7:0]  lo_q;
  logic [AW:0] cnt_q;
  logic [AW:0] idx;
  logic [AW:0] idx_next;
  logic [AW:0] cnt_sat;
  logic        accept;
  logic [7:0]  chk_byte;

  assign accept   = tx_valid && tx_ready;
  assign idx_next = idx + {{AW{1'b0}}, 1'b1};
  assign cnt_sat  = (res_count > MAX_CNT) ? MAX_CNT : res_count;

`ifdef MXV_FRAME_TX_CHECKSUM_EN
  localparam logic CHK_EN = 1'b1;
  logic [7:0] acc;
  logic       acc_clr;
  logic       acc_en;

  assign acc_clr = (state == ST_IDLE) && start;
  assign acc_en  = accept && (state != ST_SOF);

  frame_xor_acc u_xor_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .din (tx_data),
    .acc (acc)
  );

  // The byte being accepted on the transition into CHK is not yet in acc.
  assign chk_byte = acc ^ tx_data;
`else
  localparam logic CHK_EN = 1'b0;
  assign chk_byte = 8'h00;
`endif

  // What follows the last payload byte (or CMD when there is no payload).
  frame_tx_state_t tail_state;
  logic [7:0]      tail_byte;
  assign tail_state = CHK_EN ? ST_CHK : ST_EOF;
  assign tail_byte  = CHK_EN ? chk_byte : FRAME_EOF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      res_rd_en   <= 1'b0;
      res_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_q       <= 8'h00;
      lo_q        <= 8'h00;
      cnt_q       <= '0;
      idx         <= '0;
    end else begin
      done      <= 1'b0;
      res_rd_en <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          busy     <= 1'b1;
          cmd_q    <= cmd;
          cnt_q    <= cnt_sat;
          idx      <= '0;
          tx_data  <= FRAME_SOF;
          tx_valid <= 1'b1;
          state    <= ST_SOF;
        end
        ST_SOF: if (accept) begin
          tx_data <= frame_len(8'(cnt_q), CHK_EN);
          state   <= ST_LEN;
        end
        ST_LEN: if (accept) begin
          tx_data <= cmd_q;
          state   <= ST_CMD;
        end
        ST_CMD: if (accept) begin
          if (cnt_q != '0) begin
            tx_valid    <= 1'b0;
            res_rd_en   <= 1'b1;
            res_rd_addr <= idx[AW-1:0];
            state       <= ST_FETCH;
          end else begin
            tx_data <= tail_byte;
            state   <= tail_state;
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          tx_data  <= res_rd_data[15:8];
          lo_q     <= res_rd_data[7:0];
          tx_valid <= 1'b1;
          state    <= ST_HI;
        end
        ST_HI: if (accept) begin
          tx_data <= lo_q;
          state   <= ST_LO;
        end
        ST_LO: if (accept) begin
          idx <= idx_next;
          if (idx_next == cnt_q) begin
            tx_data <= tail_byte;
            state   <= tail_state;
          end else begin
            tx_valid    <= 1'b0;
            res_rd_en   <= 1'b1;
            res_rd_addr <= idx_next[AW-1:0];
            state       <= ST_FETCH;
          end
        end
        ST_CHK: if (accept) begin
          tx_data <= FRAME_EOF;
          state   <= ST_EOF;
        end
        ST_EOF: if (accept) begin
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_frame_tx.sv
// Testbench for mxv_frame_tx: directed and randomized frames checked against
// a byte-list reference model built from the frame format.
// Honours MXV_FRAME_TX_CHECKSUM_EN for the expected frame layout.
module tb_mxv_frame_tx;

  localparam int MAX_RES = 16;
`ifdef MXV_FRAME_TX_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cmd;
  logic [4:0]  res_count;
  logic [3:0]  res_rd_addr;
  logic        res_rd_en;
  logic [15:0] res_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [15:0] mem [16];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          addr_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Result buffer with one cycle read latency.
  always @(posedge clk) if (res_rd_en) res_rd_data <= mem[res_rd_addr];

  mxv_frame_tx dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cmd         (cmd),
    .res_count   (res_count),
    .res_rd_addr (res_rd_addr),
    .res_rd_en   (res_rd_en),
    .res_rd_data (res_rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int rc);
    return (rc > MAX_RES) ? MAX_RES : rc;
  endfunction

  // Reference frame: FE, LEN, CMD, payload MSB-first, [XOR], EF.
  task automatic build_exp(input logic [7:0] c, input int rc);
    int n;
    logic [7:0] len;
    logic [7:0] x;
    n   = sat(rc);
    len = 8'(1 + 2 * n + (CHK_EN ? 1 : 0));
    exp_q.delete();
    exp_q.push_back(8'hFE);
    exp_q.push_back(len);
    exp_q.push_back(c);
    x = len ^ c;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][7:0]);
      x = x ^ mem[i][15:8] ^ mem[i][7:0];
    end
    if (CHK_EN) exp_q.push_back(x);
    exp_q.push_back(8'hEF);
  endtask

  // mode: 0 ready always, 1 ready toggles, 2 ready random.
  task automatic run_frame(input string tag, input logic [7:0] c, input int rc,
                           input int mode, input bit second_start);
    int   cycles;
    int   n;
    bit   seen_done;
    bit   busy_drop;
    bit   prev_stall;
    logic [7:0] prev_data;
    n = sat(rc);
    build_exp(c, rc);
    got_q.delete();
    addr_q.delete();
    @(negedge clk);
    cmd       = c;
    res_count = 5'(rc);
    start     = 1'b1;
    tx_ready  = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cycles     = 1;
    seen_done  = 1'b0;
    busy_drop  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    check({tag, "_busy_start"}, busy, 1);
    while (cycles < 2000) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (!busy) busy_drop = 1'b1;
      if (prev_stall) begin
        check({tag, "_hold_valid"}, tx_valid, 1);
        check({tag, "_hold_data"}, tx_data, prev_data);
      end
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (res_rd_en) addr_q.push_back(int'(res_rd_addr));
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (second_start && cycles == 3) begin
        start = 1'b1;
        cmd   = ~c;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_busy_held"}, busy_drop, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    if (mode == 0) check({tag, "_latency"}, cycles, 6 + 4 * n + (CHK_EN ? 1 : 0));
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_naddr"}, addr_q.size(), n);
    for (int i = 0; i < addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), addr_q[i], i);
      check($sformatf("%s_addr_max%0d", tag, i), addr_q[i] < MAX_RES, 1);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int nacc;
    bit saw_done;
    rst       = 1'b1;
    start     = 1'b0;
    cmd       = 8'h00;
    res_count = 5'd0;
    tx_ready  = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rd_en", res_rd_en, 0);
    check("rst_rd_addr", res_rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame("t1", 8'h04, 0, 0, 1'b0);

    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    run_frame("t2", 8'h05, 2, 0, 1'b0);
    run_frame("t3", 8'h05, 2, 1, 1'b0);

    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    run_frame("t4", 8'h03, 20, 0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      run_frame($sformatf("rnd%0d", k), 8'($urandom), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset while the first payload HI byte is presented.
    mem[0] = 16'hC35A;
    mem[1] = 16'h0F0F;
    @(negedge clk);
    cmd       = 8'h01;
    res_count = 5'd2;
    start     = 1'b1;
    tx_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nacc  = 0;
    for (int i = 0; i < 50; i++) begin
      if (nacc == 3 && tx_valid) break;
      if (tx_valid && tx_ready) nacc++;
      @(negedge clk);
    end
    check("t5_hi_reached", nacc, 3);
    check("t5_hi_byte", tx_data, 8'hC3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_valid_after_rst", tx_valid, 0);
    check("t5_busy_after_rst", busy, 0);
    saw_done = done;
    repeat (10) begin
      @(negedge clk);
      saw_done = saw_done | done | tx_valid;
    end
    check("t5_no_done", saw_done, 0);
    run_frame("t5b", 8'h01, 2, 0, 1'b0);

    // Single result 0x00FF, with a second start ignored mid-frame.
    mem[0] = 16'h00FF;
    run_frame("t6", 8'h02, 1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
